// File: rtl/nn_layer_sequencer_pkg.sv
// Network shape constants and sequencer state encoding shared by the
// layer sequencer and anything that needs to know the layer geometry.
package nn_layer_sequencer_pkg;

    localparam int NUM_LAYERS = 2;
    localparam int MAX_LAYERS = 8;

    // Entries past NUM_LAYERS are placeholders so the tables always cover a 3-bit layer index.
    localparam int LAYER_IN_SIZE  [MAX_LAYERS] = '{4, 3, 1, 1, 1, 1, 1, 1};
    localparam int LAYER_OUT_SIZE [MAX_LAYERS] = '{3, 2, 1, 1, 1, 1, 1, 1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        POST  = 3'd4,
        STORE = 3'd5,
        DONE  = 3'd6
    } seq_state_t;

endpackage

// File: rtl/nn_layer_sequencer_strobe.sv
// Fixed-depth 1-bit delay line with synchronous clear; depth 0 is a wire.
module nn_strobe_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = clk ^ clr;
        assign dout      = din;
    end else begin : g_shift
        logic [DEPTH-1:0] sr_q;
        logic [DEPTH-1:0] sr_d;

        always_comb begin
            sr_d = DEPTH'({sr_q, din});
        end

        always_ff @(posedge clk) begin
            if (clr) sr_q <= '0;
            else     sr_q <= sr_d;
        end

        assign dout = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Control FSM that walks the shared dense-layer datapath through every layer:
// bias load, input issue, read-latency drain, optional ReLU, store, repeat.
module nn_layer_sequencer
    import nn_layer_sequencer_pkg::*;
#(
    parameter int                    IDX_W     = 8,
    parameter int                    RD_LAT    = 1,
    parameter logic [NUM_LAYERS-1:0] RELU_MASK = NUM_LAYERS'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       layer_idx,
    output logic [IDX_W-1:0] in_idx,
    output logic             issue_vld,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             relu_en,
    output logic             wr_en,
    output logic             rd_sel,
    output seq_state_t       dbg_state
);

    if (NUM_LAYERS < 1 || NUM_LAYERS > MAX_LAYERS) begin : g_bad_layers
        $error("NUM_LAYERS out of range");
    end
    if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_lat
        $error("RD_LAT out of range");
    end

    logic [IDX_W-1:0] last_idx [MAX_LAYERS];
    logic [7:0]       relu_vec;

    for (genvar g = 0; g < MAX_LAYERS; g++) begin : g_size
        if (g < NUM_LAYERS &&
            (LAYER_IN_SIZE[g] < 1 || LAYER_IN_SIZE[g] > (1 << IDX_W) - 1)) begin : g_bad_size
            $error("LAYER_IN_SIZE entry does not fit IDX_W");
        end
        assign last_idx[g] = IDX_W'(LAYER_IN_SIZE[g] - 1);
    end

    assign relu_vec = 8'(RELU_MASK);

    seq_state_t       state_q,     state_d;
    logic [2:0]       layer_idx_q, layer_idx_d;
    logic [IDX_W-1:0] in_idx_q,    in_idx_d;
    logic [2:0]       drain_q,     drain_d;
    logic             rd_sel_q,    rd_sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            layer_idx_q <= '0;
            in_idx_q    <= '0;
            drain_q     <= '0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            in_idx_q    <= in_idx_d;
            drain_q     <= drain_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        in_idx_d    = in_idx_q;
        drain_d     = drain_q;
        rd_sel_d    = rd_sel_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = BIAS;
                    layer_idx_d = '0;
                    rd_sel_d    = 1'b0;
                end
            end
            BIAS: begin
                state_d  = ISSUE;
                in_idx_d = '0;
            end
            ISSUE: begin
                if (in_idx_q == last_idx[layer_idx_q]) begin
                    state_d = (RD_LAT > 0) ? DRAIN : POST;
                    drain_d = 3'(RD_LAT - 1);
                end else begin
                    in_idx_d = in_idx_q + 1'b1;
                end
            end
            DRAIN: begin
                // Wait out the read pipe so the last product lands before ReLU/store.
                if (drain_q == '0) state_d = POST;
                else               drain_d = drain_q - 1'b1;
            end
            POST:  state_d = STORE;
            STORE: begin
                if (layer_idx_q == 3'(NUM_LAYERS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d     = BIAS;
                    layer_idx_d = layer_idx_q + 1'b1;
                    rd_sel_d    = ~rd_sel_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign acc_clr   = (state_q == BIAS);
    assign issue_vld = (state_q == ISSUE);
    assign relu_en   = (state_q == POST) && relu_vec[layer_idx_q];
    assign wr_en     = (state_q == STORE);
    assign layer_idx = layer_idx_q;
    assign in_idx    = in_idx_q;
    assign rd_sel    = rd_sel_q;
    assign dbg_state = state_q;

    nn_strobe_delay #(.DEPTH(RD_LAT)) u_acc_dly (
        .clk  (clk),
        .clr  (rst),
        .din  (issue_vld),
        .dout (acc_en)
    );

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: three instances (RD_LAT 1, 0, 3) share clk/rst/start.
module tb_nn_layer_sequencer;
    import nn_layer_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;

    always #5 clk = ~clk;

    logic       busy_w  [3];
    logic       done_w  [3];
    logic       clr_w   [3];
    logic       iv_w    [3];
    logic       acc_w   [3];
    logic       relu_w  [3];
    logic       wr_w    [3];
    logic       rd_w    [3];
    logic [2:0] layer_w [3];
    logic [7:0] idx_w   [3];
    seq_state_t st_w    [3];

    nn_layer_sequencer #(.IDX_W(8), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]),
        .layer_idx(layer_w[0]), .in_idx(idx_w[0]), .issue_vld(iv_w[0]), .acc_clr(clr_w[0]),
        .acc_en(acc_w[0]), .relu_en(relu_w[0]), .wr_en(wr_w[0]), .rd_sel(rd_w[0]),
        .dbg_state(st_w[0]));

    nn_layer_sequencer #(.IDX_W(8), .RD_LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[1]), .done(done_w[1]),
        .layer_idx(layer_w[1]), .in_idx(idx_w[1]), .issue_vld(iv_w[1]), .acc_clr(clr_w[1]),
        .acc_en(acc_w[1]), .relu_en(relu_w[1]), .wr_en(wr_w[1]), .rd_sel(rd_w[1]),
        .dbg_state(st_w[1]));

    nn_layer_sequencer #(.IDX_W(8), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[2]), .done(done_w[2]),
        .layer_idx(layer_w[2]), .in_idx(idx_w[2]), .issue_vld(iv_w[2]), .acc_clr(clr_w[2]),
        .acc_en(acc_w[2]), .relu_en(relu_w[2]), .wr_en(wr_w[2]), .rd_sel(rd_w[2]),
        .dbg_state(st_w[2]));

    typedef struct {
        logic [6:0] ctl;  // {busy, done, acc_clr, issue_vld, acc_en, relu_en, wr_en}
        int         rd;   // expected rd_sel and layer_idx, -1 = don't care
        int         idx;  // expected in_idx, -1 = don't care
    } row_t;

    row_t tbl [17];

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  mon_on = 1'b0;
    int  lat [3] = '{1, 0, 3};
    int  acc_cnt [3];
    logic [15:0] acc_q  [3][$];
    logic [15:0] done_q [3][$];

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, want);
        end
    endtask

    // Issue cycles become expected acc_en cycles; start acceptance becomes an expected done cycle.
    task automatic monitor();
        for (int k = 0; k < 3; k++) begin
            if (iv_w[k]) acc_q[k].push_back(16'(cyc + lat[k]));
            if (acc_w[k]) begin
                acc_cnt[k]++;
                if (acc_q[k].size() == 0) chk($sformatf("acc_en_unexpected_%0d", k), 1, 0);
                else chk($sformatf("acc_en_align_%0d", k), cyc, int'(acc_q[k].pop_front()));
            end
            if (clr_w[k]) chk($sformatf("clr_acc_overlap_%0d", k), int'(acc_w[k]), 0);
            if (done_w[k]) begin
                if (done_q[k].size() == 0) chk($sformatf("done_unexpected_%0d", k), 1, 0);
                else chk($sformatf("done_cycle_%0d", k), cyc, int'(done_q[k].pop_front()));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mon_on) monitor();
    endtask

    task automatic check_row(input int i);
        row_t r;
        r = tbl[i];
        chk($sformatf("ctl_c%0d", i + 1),
            int'({busy_w[0], done_w[0], clr_w[0], iv_w[0], acc_w[0], relu_w[0], wr_w[0]}),
            int'(r.ctl));
        if (r.rd >= 0) begin
            chk($sformatf("rd_sel_c%0d", i + 1), int'(rd_w[0]), r.rd);
            chk($sformatf("layer_c%0d", i + 1), int'(layer_w[0]), r.rd);
        end
        if (r.idx >= 0) chk($sformatf("in_idx_c%0d", i + 1), int'(idx_w[0]), r.idx);
    endtask

    task automatic check_zero(input string name);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_out_%0d", name, k),
                int'({busy_w[k], done_w[k], clr_w[k], iv_w[k], acc_w[k], relu_w[k], wr_w[k],
                      rd_w[k], layer_w[k], idx_w[k]}), 0);
            chk($sformatf("%s_state_%0d", name, k), int'(st_w[k]), int'(IDLE));
        end
    endtask

    // Start sampled at the edge closing cycle `cyc`; RD_LAT=1 outputs checked cycle by cycle.
    task automatic run_table();
        done_q[0].push_back(16'(cyc + 16));
        done_q[1].push_back(16'(cyc + 14));
        done_q[2].push_back(16'(cyc + 20));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            check_row(i);
            tick();
        end
    endtask

    task automatic check_drained(input string name);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_acc_pending_%0d", name, k), acc_q[k].size(), 0);
            chk($sformatf("%s_done_pending_%0d", name, k), done_q[k].size(), 0);
        end
    endtask

    initial begin
        tbl[0]  = '{7'b1010000, 0, -1};
        tbl[1]  = '{7'b1001000, 0,  0};
        tbl[2]  = '{7'b1001100, 0,  1};
        tbl[3]  = '{7'b1001100, 0,  2};
        tbl[4]  = '{7'b1001100, 0,  3};
        tbl[5]  = '{7'b1000100, 0, -1};
        tbl[6]  = '{7'b1000010, 0, -1};
        tbl[7]  = '{7'b1000001, 0, -1};
        tbl[8]  = '{7'b1010000, 1, -1};
        tbl[9]  = '{7'b1001000, 1,  0};
        tbl[10] = '{7'b1001100, 1,  1};
        tbl[11] = '{7'b1001100, 1,  2};
        tbl[12] = '{7'b1000100, 1, -1};
        tbl[13] = '{7'b1000000, 1, -1};
        tbl[14] = '{7'b1000001, 1, -1};
        tbl[15] = '{7'b1100000, 1, -1};
        tbl[16] = '{7'b0000000, -1, -1};

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        mon_on = 1'b1;

        // Baseline run: table for RD_LAT=1, scoreboard timing for all three latencies.
        for (int k = 0; k < 3; k++) acc_cnt[k] = 0;
        cyc = 0;
        run_table();
        repeat (6) tick();
        for (int k = 0; k < 3; k++) chk($sformatf("acc_count_%0d", k), acc_cnt[k], 7);
        check_drained("run1");

        // Starts while busy are dropped; a start in DONE is dropped, in IDLE accepted.
        cyc = 0;
        done_q[0].push_back(16'd16);
        done_q[0].push_back(16'd34);
        done_q[1].push_back(16'd14);
        done_q[1].push_back(16'd30);
        done_q[2].push_back(16'd20);
        while (cyc < 40) begin
            start = (cyc == 0 || cyc == 5 || cyc == 16 || cyc == 18);
            if (cyc == 17) chk("busy_idle_after_done", int'(busy_w[0]), 0);
            if (cyc == 19) chk("busy_second_run", int'(busy_w[0]), 1);
            tick();
        end
        start = 1'b0;
        check_drained("starts");

        // Reset during ISSUE: everything returns to idle and in-flight strobes vanish.
        cyc = 0;
        while (cyc < 4) begin
            start = (cyc == 0);
            tick();
        end
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        check_zero("midrun_reset");
        for (int k = 0; k < 3; k++) begin
            acc_q[k].delete();
            done_q[k].delete();
        end
        repeat (8) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("post_reset_busy_%0d", k), int'(busy_w[k]), 0);
                chk($sformatf("post_reset_acc_%0d", k), int'(acc_w[k]), 0);
            end
        end
        for (int k = 0; k < 3; k++) acc_cnt[k] = 0;
        cyc = 0;
        run_table();
        repeat (6) tick();
        for (int k = 0; k < 3; k++) chk($sformatf("acc_count_rerun_%0d", k), acc_cnt[k], 7);
        check_drained("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
